// File: rtl/hyperbus_burst_ctrl.sv
// HyperBus leader controller with burst support.
//
// Runs on a single clock. The system side issues read/write commands over a
// valid/ready handshake and streams write words in or read words out, one
// DDR word (2*WIDTH bits) per clk. The memory side drives a PHY word
// interface with one active-low chip select per device.
//
// Ports
//   clk, rstn          clock, asynchronous active-low reset
//   cmd_*              command request (write, register space, cs, address,
//                      length in words minus one); accepted on valid & ready
//   wr_valid/ready     write word stream (wr_data, wr_mask per RWDS edge)
//   rd_valid/data      read word stream, rd_last marks the final word,
//                      rd_error flags a timeout abort
//   busy               controller is not idle
//   phy_rstn           HyperBus device reset
//   phy_csn            active-low chip selects
//   phy_clk_en         CK gate
//   phy_dq_o/i/oe      DQ word out / in / drive enable
//   phy_rwds_o/i/oe    RWDS per edge out / in / drive enable
//
// Features: 1x/2x initial latency chosen from RWDS during CA (or forced
// 2x), zero-latency register writes, burst splitting at CSM_COUNT words
// per chip-select assertion, and read strobe timeout.
module hyperbus_burst_ctrl #(
  parameter int WIDTH          = 8,
  parameter int NUM_CS         = 2,
  parameter int CS_BITS        = 1,
  parameter int ADDR_LENGTH    = 32,
  parameter int LEN_WIDTH      = 8,
  parameter int TACC_COUNT     = 6,
  parameter int FIXED_LATENCY  = 0,
  parameter int RESET_COUNT    = 4,
  parameter int CSM_COUNT      = 64,
  parameter int RECOVERY_COUNT = 2,
  parameter int TIMEOUT_COUNT  = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic                   cmd_reg_space,
  input  logic [CS_BITS-1:0]     cmd_cs,
  input  logic [ADDR_LENGTH-1:0] cmd_adr,
  input  logic [LEN_WIDTH-1:0]   cmd_len,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [2*WIDTH-1:0]     wr_data,
  input  logic [1:0]             wr_mask,
  output logic                   rd_valid,
  output logic [2*WIDTH-1:0]     rd_data,
  output logic                   rd_last,
  output logic                   rd_error,
  output logic                   busy,
  output logic                   phy_rstn,
  output logic [NUM_CS-1:0]      phy_csn,
  output logic                   phy_clk_en,
  output logic [2*WIDTH-1:0]     phy_dq_o,
  input  logic [2*WIDTH-1:0]     phy_dq_i,
  output logic                   phy_dq_oe,
  output logic [1:0]             phy_rwds_o,
  input  logic [1:0]             phy_rwds_i,
  output logic                   phy_rwds_oe
);

  typedef enum logic [2:0] {
    S_RESET,
    S_IDLE,
    S_CMD,
    S_LATENCY,
    S_XFER,
    S_RECOVER
  } state_t;

  localparam int CNT_W = 16;
  localparam int CSM_W = $clog2(CSM_COUNT + 1);
  localparam int TO_W  = $clog2(TIMEOUT_COUNT + 1);

  localparam logic [CNT_W-1:0]       CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0]       RESET_LAST = CNT_W'(RESET_COUNT - 1);
  localparam logic [CNT_W-1:0]       REC_LAST   = CNT_W'(RECOVERY_COUNT - 1);
  localparam logic [CNT_W-1:0]       CA_LAST    = CNT_W'(2);
  localparam logic [CNT_W-1:0]       LAT_1X     = CNT_W'(TACC_COUNT);
  localparam logic [CNT_W-1:0]       LAT_2X     = CNT_W'(2 * TACC_COUNT);
  localparam logic [CSM_W-1:0]       CSM_ONE    = CSM_W'(1);
  localparam logic [CSM_W-1:0]       CSM_LAST   = CSM_W'(CSM_COUNT - 1);
  localparam logic [TO_W-1:0]        TO_ONE     = TO_W'(1);
  localparam logic [TO_W-1:0]        TO_LAST    = TO_W'(TIMEOUT_COUNT - 1);
  localparam logic [LEN_WIDTH:0]     REM_ONE    = (LEN_WIDTH+1)'(1);
  localparam logic [ADDR_LENGTH-1:0] SPLIT_STEP = ADDR_LENGTH'(CSM_COUNT * (WIDTH / 8));

  state_t                   state;
  logic [CNT_W-1:0]         cnt;        // shared by RESET, CMD, LATENCY, RECOVER
  logic [CSM_W-1:0]         csm_cnt;    // words in the current CS assertion
  logic [TO_W-1:0]          to_cnt;     // consecutive read cycles without strobe
  logic [LEN_WIDTH:0]       remaining;
  logic                     write_q;
  logic                     reg_q;
  logic [CS_BITS-1:0]       cs_q;
  logic [ADDR_LENGTH-1:0]   adr_q;
  logic                     lat_2x;
  logic                     resume_cmd; // RECOVER continues a split burst

  logic                     cs_ok;
  logic                     xfer_wr;
  logic                     xfer_rd;
  logic                     strobe;
  logic                     word_xfer;
  logic                     last_word;
  logic                     csm_full;
  logic                     timeout;
  logic [CNT_W-1:0]         lat_target;
  logic                     lat_last;
  logic                     cs_active;
  logic [47:0]              ca;
  logic [15:0]              ca_word;

  assign cs_ok      = {1'b0, cmd_cs} < (CS_BITS+1)'(NUM_CS);
  assign xfer_wr    = (state == S_XFER) && write_q;
  assign xfer_rd    = (state == S_XFER) && !write_q;
  assign strobe     = phy_rwds_i == 2'b10;
  assign word_xfer  = (xfer_wr && wr_valid) || (xfer_rd && strobe);
  assign last_word  = remaining == REM_ONE;
  assign csm_full   = csm_cnt == CSM_LAST;
  assign timeout    = xfer_rd && !strobe && (to_cnt == TO_LAST);
  assign lat_target = lat_2x ? LAT_2X : LAT_1X;
  assign lat_last   = cnt == (lat_target - CNT_ONE);
  assign cs_active  = (state == S_CMD) || (state == S_LATENCY) || (state == S_XFER);

  // Command/address: R/W#, space, linear burst, upper address, lower address.
  assign ca = {!write_q, reg_q, 1'b1, 29'(adr_q >> 3), 13'd0, adr_q[2:0]};

  always_comb begin
    case (cnt[1:0])
      2'd0:    ca_word = ca[47:32];
      2'd1:    ca_word = ca[31:16];
      default: ca_word = ca[15:0];
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_RESET;
      cnt        <= '0;
      csm_cnt    <= '0;
      to_cnt     <= '0;
      remaining  <= '0;
      write_q    <= 1'b0;
      reg_q      <= 1'b0;
      cs_q       <= '0;
      adr_q      <= '0;
      lat_2x     <= 1'b0;
      resume_cmd <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= '0;
      rd_last    <= 1'b0;
      rd_error   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_error <= 1'b0;
      if (state != S_XFER) begin
        to_cnt <= '0;
      end

      case (state)
        S_RESET: begin
          if (cnt == RESET_LAST) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_IDLE: begin
          if (cmd_valid && cs_ok) begin
            write_q   <= cmd_write;
            reg_q     <= cmd_reg_space;
            cs_q      <= cmd_cs;
            adr_q     <= cmd_adr;
            remaining <= (LEN_WIDTH+1)'(cmd_len) + REM_ONE;
            csm_cnt   <= '0;
            cnt       <= '0;
            state     <= S_CMD;
          end
        end

        S_CMD: begin
          if (cnt == CA_LAST) begin
            cnt    <= '0;
            lat_2x <= (FIXED_LATENCY != 0) || (phy_rwds_i == 2'b11);
            state  <= (write_q && reg_q) ? S_XFER : S_LATENCY;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_LATENCY: begin
          if (lat_last) begin
            cnt   <= '0;
            state <= S_XFER;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        S_XFER: begin
          if (word_xfer) begin
            remaining <= remaining - REM_ONE;
            to_cnt    <= '0;
            if (!write_q) begin
              rd_valid <= 1'b1;
              rd_data  <= phy_dq_i;
              rd_last  <= last_word;
            end
            if (last_word) begin
              csm_cnt    <= '0;
              cnt        <= '0;
              resume_cmd <= 1'b0;
              state      <= S_RECOVER;
            end else if (csm_full) begin
              // CS-low budget exhausted: reopen at the next address.
              csm_cnt    <= '0;
              cnt        <= '0;
              adr_q      <= adr_q + SPLIT_STEP;
              resume_cmd <= 1'b1;
              state      <= S_RECOVER;
            end else begin
              csm_cnt <= csm_cnt + CSM_ONE;
            end
          end else if (timeout) begin
            rd_valid   <= 1'b1;
            rd_error   <= 1'b1;
            rd_last    <= 1'b1;
            rd_data    <= '0;
            csm_cnt    <= '0;
            cnt        <= '0;
            resume_cmd <= 1'b0;
            state      <= S_RECOVER;
          end else if (xfer_rd) begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end

        S_RECOVER: begin
          if (cnt == REC_LAST) begin
            cnt   <= '0;
            state <= resume_cmd ? S_CMD : S_IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    cmd_ready   = state == S_IDLE;
    busy        = state != S_IDLE;
    phy_rstn    = state != S_RESET;
    wr_ready    = xfer_wr;
    phy_clk_en  = 1'b0;
    phy_dq_oe   = 1'b0;
    phy_dq_o    = '0;
    phy_rwds_oe = 1'b0;
    phy_rwds_o  = '0;
    phy_csn     = '1;

    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cs_active && (cs_q == CS_BITS'(i))) begin
        phy_csn[i] = 1'b0;
      end
    end

    case (state)
      S_CMD: begin
        phy_clk_en     = 1'b1;
        phy_dq_oe      = 1'b1;
        phy_dq_o[15:0] = ca_word;
      end
      S_LATENCY: begin
        phy_clk_en = 1'b1;
        // Writes drive RWDS low in the final latency cycle as mask preamble.
        phy_rwds_oe = write_q && lat_last;
      end
      S_XFER: begin
        if (write_q) begin
          phy_clk_en  = wr_valid;
          phy_dq_oe   = 1'b1;
          phy_dq_o    = wr_data;
          phy_rwds_oe = !reg_q;
          phy_rwds_o  = wr_mask;
        end else begin
          phy_clk_en = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hyperbus_burst_ctrl.sv
// Self-checking bench for hyperbus_burst_ctrl. A behavioural HyperBus device
// model answers on the PHY side; expected CA words, latency lengths, burst
// segmentation and read data are derived from the command parameters.
module tb_hyperbus_burst_ctrl;

  localparam int WIDTH    = 8;
  localparam int TACC     = 6;
  localparam int FIXED    = 0;
  localparam int RST_CNT  = 4;
  localparam int CSM      = 4;
  localparam int RECOVERY = 2;
  localparam int TIMEOUT  = 32;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic        cmd_reg_space = 1'b0;
  logic [0:0]  cmd_cs = '0;
  logic [31:0] cmd_adr = '0;
  logic [7:0]  cmd_len = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [15:0] wr_data = '0;
  logic [1:0]  wr_mask = '0;
  logic        rd_valid;
  logic [15:0] rd_data;
  logic        rd_last;
  logic        rd_error;
  logic        busy;
  logic        phy_rstn;
  logic [1:0]  phy_csn;
  logic        phy_clk_en;
  logic [15:0] phy_dq_o;
  logic [15:0] phy_dq_i = '0;
  logic        phy_dq_oe;
  logic [1:0]  phy_rwds_o;
  logic [1:0]  phy_rwds_i = '0;
  logic        phy_rwds_oe;

  int n_cmp = 0;
  int n_bad = 0;

  hyperbus_burst_ctrl #(
    .WIDTH(WIDTH), .NUM_CS(2), .CS_BITS(1), .ADDR_LENGTH(32), .LEN_WIDTH(8),
    .TACC_COUNT(TACC), .FIXED_LATENCY(FIXED), .RESET_COUNT(RST_CNT),
    .CSM_COUNT(CSM), .RECOVERY_COUNT(RECOVERY), .TIMEOUT_COUNT(TIMEOUT)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_reg_space(cmd_reg_space), .cmd_cs(cmd_cs), .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data), .wr_mask(wr_mask),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_error(rd_error),
    .busy(busy), .phy_rstn(phy_rstn), .phy_csn(phy_csn), .phy_clk_en(phy_clk_en),
    .phy_dq_o(phy_dq_o), .phy_dq_i(phy_dq_i), .phy_dq_oe(phy_dq_oe),
    .phy_rwds_o(phy_rwds_o), .phy_rwds_i(phy_rwds_i), .phy_rwds_oe(phy_rwds_oe)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d failures so far", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] csn_of(input int cs);
    logic [1:0] v;
    v = '1;
    v[cs] = 1'b0;
    return v;
  endfunction

  // 48-bit command/address built arithmetically from its field definitions.
  function automatic logic [47:0] ca_exp(input bit w, input bit r, input logic [31:0] a);
    logic [47:0] v;
    v = 48'd0;
    if (!w) v = v + 48'h8000_0000_0000;
    if (r)  v = v + 48'h4000_0000_0000;
    v = v + 48'h2000_0000_0000;
    v = v + 48'(a >> 3) * 48'd65536;
    v = v + 48'(a % 8);
    return v;
  endfunction

  task automatic issue(input bit w, input bit r, input int cs, input logic [31:0] adr, input int len);
    cmd_write = w; cmd_reg_space = r; cmd_cs = 1'(cs); cmd_adr = adr; cmd_len = 8'(len);
    cmd_valid = 1'b1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL cmd_ready: got %b expected 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  // Full transaction against the device model, including burst splitting.
  task automatic do_xact(input bit w, input bit r, input int cs, input logic [31:0] adr,
                         input int len, input logic [1:0] rwds_ca, input int gap_max,
                         input int stall_at, input int stall_n, input int wdat);
    int left, nseg, lat, seg, gap;
    logic [31:0] a;
    logic [47:0] ca;
    logic [15:0] cw, d;
    logic [1:0]  rw;
    left = len + 1; a = adr; seg = 0;
    issue(w, r, cs, adr, len);
    while (left > 0) begin
      nseg = (left < CSM) ? left : CSM;
      ca = ca_exp(w, r, a);
      for (int k = 0; k < 3; k++) begin
        phy_rwds_i = rwds_ca;
        cw = 16'(ca >> (32 - 16 * k));
        n_cmp++;
        if ({phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe, phy_dq_o} !== {csn_of(cs), 3'b110, cw}) begin
          n_bad++;
          $display("FAIL ca[%0d] seg%0d: got csn=%b ck=%b oe=%b roe=%b dq=%h expected csn=%b 110 dq=%h",
                   k, seg, phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe, phy_dq_o, csn_of(cs), cw);
        end
        tick();
      end
      phy_rwds_i = 2'b00;
      lat = (w && r) ? 0 : ((FIXED != 0 || rwds_ca == 2'b11) ? 2 * TACC : TACC);
      for (int c = 0; c < lat; c++) begin
        n_cmp++;
        if ({phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe, phy_rwds_o, wr_ready} !==
            {csn_of(cs), 1'b1, 1'b0, (w && c == lat - 1), 2'b00, 1'b0}) begin
          n_bad++;
          $display("FAIL latency[%0d/%0d]: got csn=%b ck=%b oe=%b roe=%b ro=%b wr_ready=%b expected roe=%b",
                   c, lat, phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe, phy_rwds_o, wr_ready, (w && c == lat - 1));
        end
        tick();
      end
      for (int i = 0; i < nseg; i++) begin
        if (w) begin
          if (seg == 0 && i == stall_at) begin
            for (int s = 0; s < stall_n; s++) begin
              wr_valid = 1'b0;
              #1;
              n_cmp++;
              if ({phy_csn, phy_clk_en, wr_ready, phy_dq_oe} !== {csn_of(cs), 3'b011}) begin
                n_bad++;
                $display("FAIL stall[%0d]: got csn=%b ck=%b wr_ready=%b oe=%b expected ck=0 wr_ready=1 oe=1",
                         s, phy_csn, phy_clk_en, wr_ready, phy_dq_oe);
              end
              tick();
            end
          end
          d = (wdat >= 0) ? 16'(wdat) : 16'($urandom);
          rw = 2'($urandom);
          wr_valid = 1'b1; wr_data = d; wr_mask = rw;
          #1;
          n_cmp++;
          if ({phy_csn, phy_clk_en, wr_ready, phy_dq_oe, phy_rwds_oe, phy_dq_o, phy_rwds_o} !==
              {csn_of(cs), 3'b111, !r, d, rw}) begin
            n_bad++;
            $display("FAIL wr_word[%0d]: got csn=%b ck=%b rdy=%b oe=%b roe=%b dq=%h ro=%b expected roe=%b dq=%h ro=%b",
                     i, phy_csn, phy_clk_en, wr_ready, phy_dq_oe, phy_rwds_oe, phy_dq_o, phy_rwds_o, !r, d, rw);
          end
          tick();
          wr_valid = 1'b0;
          left--;
        end else begin
          gap = $urandom_range(gap_max, 0);
          for (int g = 0; g < gap; g++) begin
            case ($urandom_range(2, 0))
              0:       phy_rwds_i = 2'b00;
              1:       phy_rwds_i = 2'b01;
              default: phy_rwds_i = 2'b11;
            endcase
            phy_dq_i = 16'($urandom);
            tick();
            n_cmp++;
            if ({rd_valid, phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe} !== {1'b0, csn_of(cs), 3'b100}) begin
              n_bad++;
              $display("FAIL rd_gap: got rd_valid=%b csn=%b ck=%b oe=%b roe=%b expected rd_valid=0",
                       rd_valid, phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe);
            end
          end
          d = 16'($urandom);
          phy_rwds_i = 2'b10; phy_dq_i = d;
          tick();
          phy_rwds_i = 2'b00;
          left--;
          n_cmp++;
          if ({rd_valid, rd_error, rd_last, rd_data} !== {1'b1, 1'b0, (left == 0), d}) begin
            n_bad++;
            $display("FAIL rd_word[%0d]: got v=%b err=%b last=%b data=%h expected v=1 err=0 last=%b data=%h",
                     i, rd_valid, rd_error, rd_last, rd_data, (left == 0), d);
          end
        end
      end
      for (int q = 0; q < RECOVERY; q++) begin
        n_cmp++;
        if ({phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe, busy, (q == 0) ? 1'b0 : rd_valid} !== {2'b11, 5'b00010}) begin
          n_bad++;
          $display("FAIL recover[%0d]: got csn=%b ck=%b oe=%b roe=%b busy=%b rd_valid=%b expected csn=11 ck=0 busy=1",
                   q, phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe, busy, rd_valid);
        end
        tick();
      end
      a = a + 32'(CSM * (WIDTH / 8));
      seg++;
    end
    n_cmp++;
    if ({cmd_ready, busy, phy_csn, rd_valid} !== {2'b10, 2'b11, 1'b0}) begin
      n_bad++;
      $display("FAIL idle_after: got ready=%b busy=%b csn=%b rd_valid=%b expected 1 0 11 0",
               cmd_ready, busy, phy_csn, rd_valid);
    end
  endtask

  task automatic test_reset();
    int n;
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if ({phy_rstn, phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe, cmd_ready, wr_ready, rd_valid, busy} !==
          {1'b0, 2'b11, 6'b000000, 1'b1}) begin
        n_bad++;
        $display("FAIL reset_hold: got rstn=%b csn=%b ck=%b ready=%b rd_valid=%b busy=%b", phy_rstn, phy_csn,
                 phy_clk_en, cmd_ready, rd_valid, busy);
      end
    end
    rstn = 1'b1;
    n = 0;
    while (phy_rstn !== 1'b1 && n < 20) begin
      n++;
      tick();
    end
    n_cmp++;
    if (n != RST_CNT) begin
      n_bad++; $display("FAIL phy_rstn_len: got %0d cycles expected %0d", n, RST_CNT);
    end
    n_cmp++;
    if ({cmd_ready, busy, phy_csn} !== {2'b10, 2'b11}) begin
      n_bad++; $display("FAIL reset_idle: got ready=%b busy=%b csn=%b expected 1 0 11", cmd_ready, busy, phy_csn);
    end
  endtask

  task automatic test_reg_write();
    logic [15:0] exp_ca [3];
    exp_ca[0] = 16'h6000; exp_ca[1] = 16'h0100; exp_ca[2] = 16'h0000;
    issue(1'b1, 1'b1, 1, 32'h800, 0);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({phy_csn, phy_clk_en, phy_dq_oe, phy_dq_o} !== {2'b01, 2'b11, exp_ca[k]}) begin
        n_bad++;
        $display("FAIL regwr_ca[%0d]: got csn=%b ck=%b oe=%b dq=%h expected csn=01 dq=%h", k, phy_csn,
                 phy_clk_en, phy_dq_oe, phy_dq_o, exp_ca[k]);
      end
      tick();
    end
    wr_valid = 1'b1; wr_data = 16'h8FE6; wr_mask = 2'b00;
    #1;
    n_cmp++;
    if ({phy_csn, phy_clk_en, wr_ready, phy_dq_oe, phy_rwds_oe, phy_dq_o} !== {2'b01, 4'b1110, 16'h8FE6}) begin
      n_bad++;
      $display("FAIL regwr_data: got csn=%b ck=%b rdy=%b oe=%b roe=%b dq=%h expected 01 1 1 1 0 8fe6",
               phy_csn, phy_clk_en, wr_ready, phy_dq_oe, phy_rwds_oe, phy_dq_o);
    end
    tick();
    wr_valid = 1'b0;
    for (int q = 0; q < RECOVERY; q++) tick();
    n_cmp++;
    if ({cmd_ready, phy_csn} !== 3'b111) begin
      n_bad++; $display("FAIL regwr_idle: got ready=%b csn=%b expected 1 11", cmd_ready, phy_csn);
    end
  endtask

  task automatic test_mem_read();
    do_xact(1'b0, 1'b0, 0, 32'h0000_1234, 3, 2'b00, 3, -1, 0, -1);
  endtask

  task automatic test_write_2x_stall();
    do_xact(1'b1, 1'b0, 1, 32'h0000_0040, 3, 2'b11, 0, 2, 2, -1);
  endtask

  task automatic test_split();
    do_xact(1'b0, 1'b0, 0, 32'h0000_0010, 9, 2'b00, 2, -1, 0, -1);
    do_xact(1'b1, 1'b0, 1, 32'h0000_0100, 5, 2'b00, 0, 1, 1, -1);
  endtask

  task automatic test_addr_wrap();
    do_xact(1'b0, 1'b0, 1, 32'hFFFF_FFFE, 5, 2'b01, 1, -1, 0, -1);
  endtask

  task automatic test_len_max();
    do_xact(1'b0, 1'b0, 0, 32'h0000_2000, 255, 2'b00, 0, -1, 0, -1);
  endtask

  task automatic test_random();
    bit w, r;
    logic [1:0] rc;
    for (int t = 0; t < 12; t++) begin
      w = 1'($urandom);
      r = ($urandom_range(3, 0) == 0);
      case ($urandom_range(2, 0))
        0:       rc = 2'b00;
        1:       rc = 2'b11;
        default: rc = 2'b01;
      endcase
      do_xact(w, r, $urandom_range(1, 0), 32'($urandom), $urandom_range(9, 0), rc, 3,
              $urandom_range(3, 0), $urandom_range(2, 0), -1);
    end
  endtask

  task automatic test_timeout();
    int n;
    logic [15:0] d;
    issue(1'b0, 1'b0, 0, 32'h0000_0300, 3);
    for (int k = 0; k < 3 + TACC; k++) tick();
    d = 16'($urandom);
    phy_rwds_i = 2'b10; phy_dq_i = d;
    tick();
    phy_rwds_i = 2'b00;
    n_cmp++;
    if ({rd_valid, rd_error, rd_last, rd_data} !== {3'b100, d}) begin
      n_bad++; $display("FAIL to_word: got v=%b err=%b last=%b data=%h expected 1 0 0 %h",
                        rd_valid, rd_error, rd_last, rd_data, d);
    end
    n = 0;
    do begin
      tick();
      n++;
    end while (rd_valid !== 1'b1 && n < 100);
    n_cmp++;
    if (n != TIMEOUT) begin
      n_bad++; $display("FAIL to_cycles: got %0d expected %0d", n, TIMEOUT);
    end
    n_cmp++;
    if ({rd_valid, rd_error, rd_last, rd_data} !== {3'b111, 16'h0000}) begin
      n_bad++; $display("FAIL to_abort: got v=%b err=%b last=%b data=%h expected 1 1 1 0000",
                        rd_valid, rd_error, rd_last, rd_data);
    end
    n_cmp++;
    if ({phy_csn, phy_clk_en} !== 3'b110) begin
      n_bad++; $display("FAIL to_recover: got csn=%b ck=%b expected 11 0", phy_csn, phy_clk_en);
    end
    for (int q = 0; q < RECOVERY; q++) tick();
    n_cmp++;
    if ({cmd_ready, busy, rd_valid} !== 3'b100) begin
      n_bad++; $display("FAIL to_idle: got ready=%b busy=%b rd_valid=%b expected 1 0 0", cmd_ready, busy, rd_valid);
    end
  endtask

  task automatic test_midburst_reset();
    int n;
    issue(1'b0, 1'b0, 1, 32'h0000_0500, 5);
    for (int k = 0; k < 3 + TACC; k++) tick();
    phy_rwds_i = 2'b10; phy_dq_i = 16'hA5A5;
    tick();
    // Strobe still present while reset hits mid-burst.
    rstn = 1'b0;
    #1;
    n_cmp++;
    if ({phy_rstn, phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe, cmd_ready, wr_ready, rd_valid, rd_last,
         rd_error, busy} !== {1'b0, 2'b11, 8'b00000000, 1'b1}) begin
      n_bad++;
      $display("FAIL midrst_now: got rstn=%b csn=%b ck=%b oe=%b roe=%b rdy=%b wrdy=%b v=%b last=%b err=%b busy=%b",
               phy_rstn, phy_csn, phy_clk_en, phy_dq_oe, phy_rwds_oe, cmd_ready, wr_ready, rd_valid,
               rd_last, rd_error, busy);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      n_cmp++;
      if ({rd_valid, phy_csn} !== 3'b011) begin
        n_bad++; $display("FAIL midrst_hold: got rd_valid=%b csn=%b expected 0 11", rd_valid, phy_csn);
      end
    end
    phy_rwds_i = 2'b00;
    rstn = 1'b1;
    n = 0;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_cmp++;
    if (n != RST_CNT) begin
      n_bad++; $display("FAIL midrst_recover: got %0d cycles to idle expected %0d", n, RST_CNT);
    end
  endtask

  initial begin
    test_reset();
    test_reg_write();
    test_mem_read();
    test_write_2x_stall();
    test_split();
    test_addr_wrap();
    test_len_max();
    test_random();
    test_timeout();
    test_midburst_reset();
    test_mem_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
